// File: rtl/irq_controller.sv
// irq_controller: NUM_IRQ-source maskable fixed-priority interrupt controller for the MIPS control unit.
// Latency: irq_in -> irq is SYNC_STAGES+2 cycles; register reads are combinational.
// Backpressure: a request holds in REQ until irq_entry; define IRQ_EDGE_EN for edge-latched pending with W1C.
module irq_controller #(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0180,
    parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010,
    parameter logic [31:0] MASK_RST    = 32'h0000_0000,
    parameter int          CNT_W       = 16,
    localparam int         ID_W        = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               irq_entry,
    input  logic               irq_resume,
    input  logic               bus_we,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               irq,
    output logic               irq_active,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        irq_vector
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

    localparam logic [NUM_IRQ-1:0] MASK_INIT = MASK_RST[NUM_IRQ-1:0];

    state_t             state;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] elig;
    logic [ID_W-1:0]    winner;
    logic [CNT_W-1:0]   svc_cnt;
    logic               entry_acc;
    logic               req_drop;
    logic               mask_wr;
    logic               cnt_clr;
    logic               unused_wdata;

    assign mask_wr      = bus_we && (bus_addr == 2'd0);
    assign cnt_clr      = bus_we && (bus_addr == 2'd3);
    assign elig         = pending & mask;
    assign entry_acc    = (state == REQ) && irq_entry;
    assign unused_wdata = ^bus_wdata;

    // Optional synchroniser chain on every raw interrupt line
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq_in;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] stage_q [SYNC_STAGES];
            // Shift raw lines through SYNC_STAGES flops
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= irq_in;
                    for (int k = 1; k < SYNC_STAGES; k++) stage_q[k] <= stage_q[k-1];
                end
            end
            assign irq_s = stage_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_s_prev;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] entry_onehot;

    assign pend_set     = irq_s & ~irq_s_prev;
    assign entry_onehot = entry_acc ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id) : '0;
    assign pend_clr     = ((bus_we && bus_addr == 2'd1) ? bus_wdata[NUM_IRQ-1:0] : '0) | entry_onehot;
    // Only masking can withdraw a latched edge request
    assign req_drop     = !mask[irq_id];

    // Latch rising edges; clears from W1C or entry lose to a simultaneous new edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            irq_s_prev <= '0;
        end else begin
            pending    <= (pending & ~pend_clr) | pend_set;
            irq_s_prev <= irq_s;
        end
    end
`else
    // Level request is withdrawn when the line drops or gets masked
    assign req_drop = !elig[irq_id];

    // Level mode: pending simply mirrors the synchronised lines
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= irq_s;
    end
`endif

    // Mask register, bit = 1 enables the source
    always_ff @(posedge clk) begin
        if (rst)          mask <= MASK_INIT;
        else if (mask_wr) mask <= bus_wdata[NUM_IRQ-1:0];
    end

    // Fixed priority: lowest eligible index wins
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) winner = ID_W'(i);
        end
    end

    // Request/service FSM with registered outputs and saturating service counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_active <= 1'b0;
            irq_id     <= '0;
            svc_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        state  <= REQ;
                        irq    <= 1'b1;
                        irq_id <= winner;
                    end
                end
                REQ: begin
                    if (irq_entry) begin
                        state      <= ACTIVE;
                        irq        <= 1'b0;
                        irq_active <= 1'b1;
                    end else if (req_drop) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (irq_resume) begin
                        state      <= IDLE;
                        irq_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    irq        <= 1'b0;
                    irq_active <= 1'b0;
                end
            endcase
            if (cnt_clr)                             svc_cnt <= entry_acc ? CNT_W'(1) : '0;
            else if (entry_acc && (svc_cnt != '1))   svc_cnt <= svc_cnt + CNT_W'(1);
        end
    end

    assign irq_vector = VEC_BASE + 32'(irq_id) * VEC_STRIDE;

    // Register window read mux; unused high bits read as zero
    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            2'd0: bus_rdata[NUM_IRQ-1:0] = mask;
            2'd1: bus_rdata[NUM_IRQ-1:0] = pending;
            2'd2: begin
                bus_rdata[31]       = irq_active;
                bus_rdata[30]       = irq;
                bus_rdata[ID_W-1:0] = irq_id;
            end
            default: bus_rdata[CNT_W-1:0] = svc_cnt;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed literal checks plus randomized traffic against a behavioural model.
// Latency: model predicts outputs after every clock edge; compared on the falling edge.
// Backpressure: entry/resume driven randomly, including out-of-state (ignored) events.
module tb_irq_controller;
    localparam int          NUM   = 8;
    localparam int          SYNC  = 2;
    localparam int          CNT_W = 4;
    localparam int          ID_W  = 3;
    localparam logic [31:0] VB    = 32'h0000_0180;
    localparam logic [31:0] VS    = 32'h0000_0010;
    localparam logic [31:0] MRST  = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NUM-1:0]  irq_in = '0;
    logic            irq_entry = 1'b0;
    logic            irq_resume = 1'b0;
    logic            bus_we = 1'b0;
    logic [1:0]      bus_addr = 2'd0;
    logic [31:0]     bus_wdata = '0;
    logic [31:0]     bus_rdata;
    logic            irq;
    logic            irq_active;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     irq_vector;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    irq_controller #(
        .NUM_IRQ(NUM), .SYNC_STAGES(SYNC), .VEC_BASE(VB), .VEC_STRIDE(VS),
        .MASK_RST(MRST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_entry(irq_entry),
        .irq_resume(irq_resume), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
        .irq_active(irq_active), .irq_id(irq_id), .irq_vector(irq_vector)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [NUM-1:0] m_hist[$];   // irq_in history, newest first
    logic [NUM-1:0] m_pend, m_mask, m_prev;
    bit             m_req, m_act;
    int             m_id, m_cnt;

    task automatic model_step();
        logic [NUM-1:0] s, elig, clr;
        logic [31:0]    tmp;
        bit             acc, keep;
        bit             found;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
            tmp = MRST;
            m_pend = '0; m_mask = tmp[NUM-1:0]; m_prev = '0;
            m_req = 0; m_act = 0; m_id = 0; m_cnt = 0;
            return;
        end
        s    = m_hist[SYNC-1];
        elig = m_pend & m_mask;
        acc  = m_req && irq_entry;
`ifdef IRQ_EDGE_EN
        keep = m_mask[m_id];
`else
        keep = elig[m_id];
`endif
        // service state
        if (m_act) begin
            if (irq_resume) m_act = 0;
        end else if (m_req) begin
            if (irq_entry) begin m_req = 0; m_act = 1; end
            else if (!keep) m_req = 0;
        end else if (elig != '0) begin
            found = 0;
            for (int i = 0; i < NUM; i++) begin
                if (elig[i] && !found) begin m_id = i; found = 1; end
            end
            m_req = 1;
        end
        // counter
        if (bus_we && bus_addr == 2'd3) m_cnt = acc ? 1 : 0;
        else if (acc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        // pending
`ifdef IRQ_EDGE_EN
        clr = '0;
        if (bus_we && bus_addr == 2'd1) clr = bus_wdata[NUM-1:0];
        if (acc) clr[m_id] = 1'b1;
        m_pend = (m_pend & ~clr) | (s & ~m_prev);
        m_prev = s;
`else
        m_pend = s;
`endif
        if (bus_we && bus_addr == 2'd0) m_mask = bus_wdata[NUM-1:0];
        m_hist.push_front(irq_in);
        void'(m_hist.pop_back());
    endtask

    function automatic logic [31:0] model_rdata(logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = 32'(m_mask);
            2'd1: r = 32'(m_pend);
            2'd2: begin
                r[31] = m_act;
                r[30] = m_req;
                r[ID_W-1:0] = m_id[ID_W-1:0];
            end
            default: r = 32'(m_cnt);
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: advance model on rising edge, check on falling edge
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (chk_en) begin
                chk("m_irq", 32'(irq), 32'(m_req));
                chk("m_irq_active", 32'(irq_active), 32'(m_act));
                chk("m_irq_id", 32'(irq_id), 32'(m_id));
                if (m_req || m_act) chk("m_irq_vector", irq_vector, VB + 32'(m_id) * VS);
                chk("m_bus_rdata", bus_rdata, model_rdata(bus_addr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = '0; irq_entry = 0; irq_resume = 0; bus_we = 0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick(1);
        bus_we = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(name, bus_rdata, exp);
    endtask

    task automatic pulse_entry();
        irq_entry = 1'b1; tick(1); irq_entry = 1'b0;
    endtask

    task automatic pulse_resume();
        irq_resume = 1'b1; tick(1); irq_resume = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL %s: irq=%b after %0d cycles, expected 1", name, irq, budget);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        chk_en = 1'b1;

        // reset state
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_active", 32'(irq_active), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        read_chk("rst_mask", 2'd0, 32'h0);
        read_chk("rst_pending", 2'd1, 32'h0);
        read_chk("rst_count", 2'd3, 32'h0);

        // basic latency, vector and service count
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h08;
        tick(SYNC + 1);
        chk("lat_early", 32'(irq), 32'd0);
        tick(1);
        chk("lat_irq", 32'(irq), 32'd1);
        chk("lat_id", 32'(irq_id), 32'd3);
        chk("lat_vector", irq_vector, 32'h0000_01B0);
        read_chk("status_req", 2'd2, 32'h4000_0003);
        pulse_entry();
        chk("entry_irq", 32'(irq), 32'd0);
        chk("entry_active", 32'(irq_active), 32'd1);
        read_chk("entry_count", 2'd3, 32'd1);
        pulse_resume();
        chk("resume_active", 32'(irq_active), 32'd0);
        chk("resume_gap", 32'(irq), 32'd0);
        irq_in = '0;
        tick(6);

        // priority and frozen id
        do_reset();
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h22;
        tick(SYNC + 2);
        chk("prio_id", 32'(irq_id), 32'd1);
        irq_in = 8'h23;
        tick(3);
        chk("frozen_id", 32'(irq_id), 32'd1);
        chk("frozen_irq", 32'(irq), 32'd1);
        pulse_entry();
        pulse_resume();
        tick(1);
        chk("next_irq", 32'(irq), 32'd1);
        chk("next_id", 32'(irq_id), 32'd0);
        irq_in = '0;

        // masking
        do_reset();
        irq_in = 8'h04;
        tick(SYNC + 4);
        chk("masked_irq", 32'(irq), 32'd0);
        write_reg(2'd0, 32'h04);
        chk("mask_wr_1", 32'(irq), 32'd0);
        tick(1);
        chk("mask_wr_2", 32'(irq), 32'd1);
        write_reg(2'd0, 32'h00);
        chk("unmask_0", 32'(irq), 32'd1);
        tick(1);
        chk("unmask_1", 32'(irq), 32'd0);
        irq_in = '0;

`ifndef IRQ_EDGE_EN
        // level drop before entry
        do_reset();
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h10;
        tick(SYNC + 2);
        chk("drop_req", 32'(irq), 32'd1);
        irq_in = '0;
        tick(SYNC + 1);
        chk("drop_hold", 32'(irq), 32'd1);
        tick(1);
        chk("drop_irq", 32'(irq), 32'd0);
        read_chk("drop_count", 2'd3, 32'd0);
`else
        // edge latching, entry clear, W1C against a new edge
        do_reset();
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h40;
        tick(1);
        irq_in = '0;
        tick(SYNC);
        read_chk("edge_pend", 2'd1, 32'h40);
        tick(1);
        chk("edge_irq", 32'(irq), 32'd1);
        chk("edge_id", 32'(irq_id), 32'd6);
        tick(3);
        read_chk("edge_sticky", 2'd1, 32'h40);
        pulse_entry();
        read_chk("edge_entry_clr", 2'd1, 32'h0);
        pulse_resume();
        irq_in = 8'h40;
        for (int c = 0; c <= SYNC; c++) begin
            if (c == SYNC) begin
                bus_we = 1'b1; bus_addr = 2'd1; bus_wdata = 32'h40;
            end
            tick(1);
            irq_in = '0;
        end
        bus_we = 1'b0;
        read_chk("edge_set_wins", 2'd1, 32'h40);
        tick(4);
`endif

        // counter saturation and clear
        do_reset();
        write_reg(2'd0, 32'h01);
        irq_in = 8'h01;
        for (int k = 0; k < 17; k++) begin
            wait_irq("sat_wait", 12);
            pulse_entry();
            irq_in = '0;
            tick(1);
            irq_in = 8'h01;
            pulse_resume();
        end
        read_chk("sat_count", 2'd3, 32'd15);
        write_reg(2'd3, 32'h1234);
        read_chk("clr_count", 2'd3, 32'd0);
        wait_irq("clr_wait", 12);
        bus_we = 1'b1; bus_addr = 2'd3; bus_wdata = '0;
        pulse_entry();
        bus_we = 1'b0;
        read_chk("clr_with_entry", 2'd3, 32'd1);

        // reset during ACTIVE
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_active", 32'(irq_active), 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        read_chk("midrst_count", 2'd3, 32'd0);
        read_chk("midrst_mask", 2'd0, MRST);
        pulse_resume();
        chk("post_rst_resume", 32'(irq_active), 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);
        irq_in = '0;

        // randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NUM; b++) begin
                if ($urandom_range(0, 15) == 0) irq_in[b] = ~irq_in[b];
            end
            irq_entry  = ($urandom_range(0, 3) == 0);
            irq_resume = ($urandom_range(0, 3) == 0);
            bus_addr   = 2'($urandom_range(0, 3));
            bus_we     = ($urandom_range(0, 19) == 0);
            bus_wdata  = $urandom;
            rst        = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0; irq_entry = 0; irq_resume = 0; bus_we = 0; irq_in = '0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
